// File: rtl/ddr3_arb_pkg.sv
// ddr3_arb_pkg: shared types, constants and helpers for the DDR3 channel arbiter.
package ddr3_arb_pkg;

    // Number of requesting channels; channel ids are 2 bits wide.
    localparam int NCH = 3;

    // Arbitration policy carried in arb_mode[2:1].
    typedef enum logic [1:0] {
        ARB_FIXED = 2'b00,
        ARB_RR    = 2'b01,
        ARB_WRR   = 2'b10
    } arb_pol_e;

    // Arbiter FSM states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    // Fallback fixed order ch0 > ch1 > ch2, highest-priority id in the LSBs.
    localparam logic [5:0] DEFAULT_ORDER = 6'b10_01_00;

    // Policy 2'b11 is reserved and behaves as fixed priority.
    function automatic arb_pol_e decode_pol(input logic [1:0] bits);
        return (bits == 2'b11) ? ARB_FIXED : arb_pol_e'(bits);
    endfunction

    // Next channel id, wrapping 2 -> 0.
    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
    endfunction

    // A programmed weight of zero still earns one grant per turn.
    function automatic logic [3:0] eff_weight(input logic [3:0] w);
        return (w == 4'd0) ? 4'd1 : w;
    endfunction

    // A priority order is usable only if every field names a real, distinct channel.
    function automatic logic order_valid(input logic [5:0] o);
        logic [1:0] a, b, c;
        a = o[1:0];
        b = o[3:2];
        c = o[5:4];
        return (a != 2'd3) && (b != 2'd3) && (c != 2'd3) &&
               (a != b) && (a != c) && (b != c);
    endfunction

endpackage

// File: rtl/ddr3_arb_pick.sv
// ddr3_arb_pick: combinational winner select. Walks an ordered list of channel
// ids (first entry in the LSBs) and grants the first requester; any promoted
// channel overrides the list, lowest id first.
module ddr3_arb_pick
    import ddr3_arb_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [2*NCH-1:0] order,
    input  logic [NCH-1:0]   promo,
    output logic [NCH-1:0]   gnt,
    output logic [1:0]       id
);

    logic       found;
    logic [1:0] cand;

    // Priority walk: promoted channels first, otherwise the supplied order.
    always_comb begin
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        cand  = '0;
        if (|promo) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (!found && promo[i]) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    id     = 2'(i);
                end
            end
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                cand = order[2*k +: 2];
                if (!found && (cand != 2'd3) && req[cand]) begin
                    found     = 1'b1;
                    gnt[cand] = 1'b1;
                    id        = cand;
                end
            end
        end
    end

endmodule

// File: rtl/ddr3_ch_arbiter.sv
// ddr3_ch_arbiter: three-channel command arbiter for the DDR3 controller
// command port. Fixed priority, round robin or weighted round robin, chosen by
// arb_mode. Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module ddr3_ch_arbiter #(
    parameter int NCH          = 3,
    parameter int AW           = 28,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic [2:0]        arb_mode,
    input  logic [2*NCH-1:0]  prio_set,
    input  logic [3:0]        weight0,
    input  logic [3:0]        weight1,
    input  logic [3:0]        weight2,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH-1:0]    ch_wr,
    output logic [NCH-1:0]    ch_gnt,
    output logic              mc_vld,
    input  logic              mc_ready,
    output logic [AW-1:0]     mc_addr,
    output logic              mc_wr,
    output logic [1:0]        mc_ch,
    output logic              busy
);
    import ddr3_arb_pkg::*;

    arb_state_e       state_q;
    logic [1:0]       rr_ptr_q;
    logic [3:0]       credit_q   [NCH];
    arb_pol_e         last_pol_q;
    arb_pol_e         win_pol_q;
    logic             wrr_switch_q;
    logic             promo_win_q;
    logic [3:0]       wrr_load_q;

    arb_pol_e         pol;
    logic [3:0]       wt_eff     [NCH];
    logic [3:0]       credit_eff [NCH];
    logic             reload_all;
    logic             owner_ok;
    logic             arb_go;
    logic [2*NCH-1:0] order;
    logic [NCH-1:0]   promo;
    logic [NCH-1:0]   pick_gnt;
    logic [1:0]       pick_id;

    // Policy decode, effective weights and the credits seen by this arbitration.
    // Credits reload on the first IDLE cycle in WRR, so that cycle already uses the weights.
    always_comb begin
        pol        = decode_pol(arb_mode[2:1]);
        reload_all = (pol == ARB_WRR) && (last_pol_q != ARB_WRR);
        wt_eff[0]  = eff_weight(weight0);
        wt_eff[1]  = eff_weight(weight1);
        wt_eff[2]  = eff_weight(weight2);
        for (int unsigned i = 0; i < NCH; i++) begin
            credit_eff[i] = reload_all ? wt_eff[i] : credit_q[i];
        end
        owner_ok = ch_req[rr_ptr_q] && (credit_eff[rr_ptr_q] != 4'd0);
        arb_go   = (state_q == IDLE) && arb_mode[0] && (|ch_req);
    end

    // Build the search order for the active policy.
    // WRR: the owner leads while it may keep the grant; otherwise the search
    // starts after the owner and the owner comes last (reload if it is alone).
    always_comb begin
        order = DEFAULT_ORDER;
        case (pol)
            ARB_RR:  order = {next_ch(next_ch(rr_ptr_q)), next_ch(rr_ptr_q), rr_ptr_q};
            ARB_WRR: order = owner_ok ?
                             {next_ch(next_ch(rr_ptr_q)), next_ch(rr_ptr_q), rr_ptr_q} :
                             {rr_ptr_q, next_ch(next_ch(rr_ptr_q)), next_ch(rr_ptr_q)};
            default: order = order_valid(prio_set) ? prio_set : DEFAULT_ORDER;
        endcase
    end

    ddr3_arb_pick u_pick (
        .req   (ch_req),
        .order (order),
        .promo (promo),
        .gnt   (pick_gnt),
        .id    (pick_id)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    logic [WW-1:0] wait_q [NCH];

    // A requester that has waited STARVE_LIMIT grants is promoted.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            promo[i] = ch_req[i] && (wait_q[i] >= WW'(STARVE_LIMIT));
        end
    end

    // Wait counters: count grants lost while requesting, saturating at the limit.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            for (int unsigned i = 0; i < NCH; i++) wait_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (!ch_req[i] || (arb_go && pick_gnt[i])) begin
                    wait_q[i] <= '0;
                end else if (arb_go && (wait_q[i] < WW'(STARVE_LIMIT))) begin
                    wait_q[i] <= wait_q[i] + 1'b1;
                end
            end
        end
    end
`else
    // No starvation guard: pure policy behaviour.
    always_comb promo = '0;
`endif

    // Grant pulse and handshake outputs.
    always_comb begin
        ch_gnt = (arb_go && areset_n) ? pick_gnt : '0;
        mc_vld = (state_q == ISSUE);
        busy   = (state_q == ISSUE);
    end

    // FSM, command capture and post-issue policy update.
    // The WRR outcome (keep owner or switch with reload) is decided at grant
    // time and committed only when the controller accepts the command.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            for (int unsigned i = 0; i < NCH; i++) credit_q[i] <= '0;
            last_pol_q   <= ARB_FIXED;
            win_pol_q    <= ARB_FIXED;
            wrr_switch_q <= 1'b0;
            promo_win_q  <= 1'b0;
            wrr_load_q   <= '0;
            mc_addr      <= '0;
            mc_wr        <= 1'b0;
            mc_ch        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    last_pol_q <= pol;
                    if (reload_all) begin
                        for (int unsigned i = 0; i < NCH; i++) credit_q[i] <= wt_eff[i];
                    end
                    if (arb_go) begin
                        state_q      <= ISSUE;
                        mc_addr      <= ch_addr[pick_id*AW +: AW];
                        mc_wr        <= ch_wr[pick_id];
                        mc_ch        <= pick_id;
                        win_pol_q    <= pol;
                        wrr_switch_q <= !owner_ok;
                        wrr_load_q   <= wt_eff[pick_id];
                        promo_win_q  <= |promo;
                    end
                end
                ISSUE: begin
                    if (mc_ready) begin
                        state_q <= IDLE;
                        case (win_pol_q)
                            ARB_RR: rr_ptr_q <= next_ch(mc_ch);
                            ARB_WRR: begin
                                if (!promo_win_q) begin
                                    if (wrr_switch_q) begin
                                        rr_ptr_q <= mc_ch;
                                        for (int unsigned i = 0; i < NCH; i++) begin
                                            if (2'(i) == mc_ch) credit_q[i] <= wrr_load_q - 4'd1;
                                        end
                                    end else begin
                                        for (int unsigned i = 0; i < NCH; i++) begin
                                            if (2'(i) == rr_ptr_q) credit_q[i] <= credit_q[i] - 4'd1;
                                        end
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_ch_arbiter.sv
// tb_ddr3_ch_arbiter: vector table, hand-written stall/reset sequences and a
// randomized run checked against a rule-level reference model.
module tb_ddr3_ch_arbiter;

    localparam int AW = 28;

    logic          aclk;
    logic          areset_n;
    logic [2:0]    arb_mode;
    logic [5:0]    prio_set;
    logic [3:0]    weight0, weight1, weight2;
    logic [2:0]    ch_req;
    logic [3*AW-1:0] ch_addr;
    logic [2:0]    ch_wr;
    logic [2:0]    ch_gnt;
    logic          mc_vld;
    logic          mc_ready;
    logic [AW-1:0] mc_addr;
    logic          mc_wr;
    logic [1:0]    mc_ch;
    logic          busy;

    ddr3_ch_arbiter #(.NCH(3), .AW(AW), .STARVE_LIMIT(8)) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .arb_mode (arb_mode),
        .prio_set (prio_set),
        .weight0  (weight0),
        .weight1  (weight1),
        .weight2  (weight2),
        .ch_req   (ch_req),
        .ch_addr  (ch_addr),
        .ch_wr    (ch_wr),
        .ch_gnt   (ch_gnt),
        .mc_vld   (mc_vld),
        .mc_ready (mc_ready),
        .mc_addr  (mc_addr),
        .mc_wr    (mc_wr),
        .mc_ch    (mc_ch),
        .busy     (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] a [3];
    logic [2:0]    wrs;

    typedef struct {
        logic [2:0] mode;
        logic [5:0] prio;
        logic [3:0] w0, w1, w2;
        logic [2:0] req;
        logic [2:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic new_addrs();
        for (int i = 0; i < 3; i++) a[i] = AW'($urandom);
        wrs     = 3'($urandom);
        ch_addr = {a[2], a[1], a[0]};
        ch_wr   = wrs;
    endtask

    function automatic logic [2:0] oh(input int i);
        logic [2:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic vec_t mk(input logic [2:0] mode, input logic [5:0] prio,
                                input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2,
                                input logic [2:0] req, input logic [2:0] exp);
        vec_t v;
        v.mode = mode; v.prio = prio; v.w0 = w0; v.w1 = w1; v.w2 = w2;
        v.req  = req;  v.exp  = exp;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge aclk);
        areset_n = 1'b0;
        ch_req   = '0;
        @(negedge aclk);
        areset_n = 1'b1;
    endtask

    // One transaction: drive in IDLE, check the grant pulse, then the issued command.
    task automatic run_vec(input vec_t v, input int idx);
        int            id;
        logic [AW-1:0] ea;
        logic          ew;
        @(negedge aclk);
        arb_mode = v.mode; prio_set = v.prio;
        weight0 = v.w0; weight1 = v.w1; weight2 = v.w2;
        ch_req = v.req; mc_ready = 1'b1;
        new_addrs();
        #1;
        chk($sformatf("vec%0d ch_gnt", idx), 32'(ch_gnt), 32'(v.exp));
        id = (v.exp == 3'b010) ? 1 : (v.exp == 3'b100) ? 2 : 0;
        ea = a[id];
        ew = wrs[id];
        @(negedge aclk);
        #1;
        if (v.exp != 3'b000) begin
            chk($sformatf("vec%0d mc_vld", idx),  32'(mc_vld),  32'd1);
            chk($sformatf("vec%0d mc_ch", idx),   32'(mc_ch),   32'(id));
            chk($sformatf("vec%0d mc_addr", idx), 32'(mc_addr), 32'(ea));
            chk($sformatf("vec%0d mc_wr", idx),   32'(mc_wr),   32'(ew));
            chk($sformatf("vec%0d gnt_in_issue", idx), 32'(ch_gnt), 32'd0);
        end else begin
            chk($sformatf("vec%0d mc_vld_idle", idx), 32'(mc_vld), 32'd0);
        end
    endtask

    // Reference model state (rule level)
    bit            m_issue;
    int            m_ptr;
    int            m_cred [3];
    bit            m_lastwrr;
    int            m_ch;
    logic [AW-1:0] m_addr;
    logic          m_wr;
    int            m_pol;
    int            m_post_ptr;
    int            m_post_cred;

    function automatic int wt(input int i);
        logic [3:0] w;
        w = (i == 0) ? weight0 : (i == 1) ? weight1 : weight2;
        return (w == 4'd0) ? 1 : int'(w);
    endfunction

    initial begin
        int         pol, win;
        bit         reload, kept;
        int         ce [3];
        int         f [3];
        logic [2:0] eg, prev_gnt;
        logic [AW-1:0] a0;

        // ---------------- reset state ----------------
        areset_n = 1'b0;
        arb_mode = 3'b001; prio_set = 6'b10_01_00;
        weight0 = '0; weight1 = '0; weight2 = '0;
        ch_req = 3'b111; mc_ready = 1'b0;
        new_addrs();
        repeat (2) @(negedge aclk);
        #1;
        chk("rst ch_gnt",  32'(ch_gnt),  32'd0);
        chk("rst mc_vld",  32'(mc_vld),  32'd0);
        chk("rst busy",    32'(busy),    32'd0);
        chk("rst mc_addr", 32'(mc_addr), 32'd0);
        chk("rst mc_wr",   32'(mc_wr),   32'd0);
        chk("rst mc_ch",   32'(mc_ch),   32'd0);

        // ---------------- stall then reset mid-ISSUE ----------------
        areset_n = 1'b1;
        #1;
        chk("stall grant", 32'(ch_gnt), 32'b001);
        a0 = a[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            ch_req = 3'b110;
            new_addrs();
            #1;
            chk($sformatf("stall%0d mc_vld", c),  32'(mc_vld),  32'd1);
            chk($sformatf("stall%0d busy", c),    32'(busy),    32'd1);
            chk($sformatf("stall%0d ch_gnt", c),  32'(ch_gnt),  32'd0);
            chk($sformatf("stall%0d mc_addr", c), 32'(mc_addr), 32'(a0));
            chk($sformatf("stall%0d mc_ch", c),   32'(mc_ch),   32'd0);
        end
        @(negedge aclk);
        areset_n = 1'b0;
        @(negedge aclk);
        #1;
        chk("midrst mc_vld",  32'(mc_vld),  32'd0);
        chk("midrst busy",    32'(busy),    32'd0);
        chk("midrst mc_addr", 32'(mc_addr), 32'd0);
        areset_n = 1'b1;
        arb_mode = 3'b011; ch_req = 3'b111; mc_ready = 1'b1;
        #1;
        chk("rerequest grant", 32'(ch_gnt), 32'b001);
        @(negedge aclk);
        #1;
        chk("rerequest mc_vld", 32'(mc_vld), 32'd1);

        // ---------------- vector table ----------------
        tbl.push_back(mk(3'b001, 6'b00_01_10, 4'd0, 4'd0, 4'd0, 3'b111, 3'b100));
        tbl.push_back(mk(3'b001, 6'b00_01_10, 4'd0, 4'd0, 4'd0, 3'b011, 3'b010));
        tbl.push_back(mk(3'b001, 6'b00_01_10, 4'd0, 4'd0, 4'd0, 3'b001, 3'b001));
        tbl.push_back(mk(3'b001, 6'b01_01_00, 4'd0, 4'd0, 4'd0, 3'b110, 3'b010));
        tbl.push_back(mk(3'b001, 6'b11_00_01, 4'd0, 4'd0, 4'd0, 3'b111, 3'b001));
        tbl.push_back(mk(3'b001, 6'b10_00_01, 4'd0, 4'd0, 4'd0, 3'b101, 3'b001));
        tbl.push_back(mk(3'b001, 6'b10_00_01, 4'd0, 4'd0, 4'd0, 3'b111, 3'b010));
        tbl.push_back(mk(3'b111, 6'b00_01_10, 4'd0, 4'd0, 4'd0, 3'b111, 3'b100));
        tbl.push_back(mk(3'b000, 6'b00_01_10, 4'd0, 4'd0, 4'd0, 3'b111, 3'b000));
        foreach (tbl[i]) begin end
        begin
            int rr1 [6]  = '{0, 1, 2, 0, 1, 2};
            int rr2 [4]  = '{0, 2, 0, 2};
            int wr1 [12] = '{0, 0, 0, 1, 2, 2, 0, 0, 0, 1, 2, 2};
            int wr2 [8]  = '{2, 2, 0, 0, 0, 1, 2, 2};
            int wr3 [4]  = '{0, 0, 0, 1};
            foreach (rr1[i]) tbl.push_back(mk(3'b011, 6'd0, 4'd0, 4'd0, 4'd0, 3'b111, oh(rr1[i])));
            foreach (rr2[i]) tbl.push_back(mk(3'b011, 6'd0, 4'd0, 4'd0, 4'd0, 3'b101, oh(rr2[i])));
            foreach (wr1[i]) tbl.push_back(mk(3'b101, 6'd0, 4'd3, 4'd1, 4'd2, 3'b111, oh(wr1[i])));
            tbl.push_back(mk(3'b001, 6'b00_01_10, 4'd3, 4'd1, 4'd2, 3'b111, 3'b100));
            foreach (wr2[i]) tbl.push_back(mk(3'b101, 6'd0, 4'd3, 4'd0, 4'd2, 3'b111, oh(wr2[i])));
            foreach (wr3[i]) tbl.push_back(mk(3'b101, 6'd0, 4'd3, 4'd1, 4'd2, 3'b011, oh(wr3[i])));
            tbl.push_back(mk(3'b101, 6'd0, 4'd3, 4'd1, 4'd2, 3'b101, 3'b100));
            tbl.push_back(mk(3'b101, 6'd0, 4'd3, 4'd1, 4'd2, 3'b001, 3'b001));
        end
        do_reset();
        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

`ifdef ARB_STARVE_GUARD_EN
        // ---------------- starvation promotion ----------------
        arb_mode = 3'b001;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            run_vec(mk(3'b001, 6'b10_01_00, 4'd0, 4'd0, 4'd0, 3'b101,
                       (i == 8) ? 3'b100 : 3'b001), 100 + i);
        end
`else
        // ---------------- randomized run against the model ----------------
        arb_mode = 3'b001;
        do_reset();
        m_issue = 0; m_ptr = 0; m_lastwrr = 0; m_ch = 0; m_addr = '0; m_wr = 1'b0;
        m_pol = 0; m_post_ptr = 0; m_post_cred = 0;
        for (int i = 0; i < 3; i++) m_cred[i] = 0;
        prev_gnt = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge aclk);
            ch_req = ch_req & ~prev_gnt;
            if ($urandom_range(0, 19) == 0) begin
                arb_mode = {2'($urandom), ($urandom_range(0, 7) != 0)};
                prio_set = 6'($urandom);
                weight0  = 4'($urandom); weight1 = 4'($urandom); weight2 = 4'($urandom);
            end
            for (int i = 0; i < 3; i++) begin
                if (!ch_req[i] && $urandom_range(0, 3) == 0) ch_req[i] = 1'b1;
                else if (ch_req[i] && $urandom_range(0, 15) == 0) ch_req[i] = 1'b0;
            end
            new_addrs();
            mc_ready = ($urandom_range(0, 2) != 0);
            #1;
            pol    = (arb_mode[2:1] == 2'b11) ? 0 : int'(arb_mode[2:1]);
            reload = (pol == 2) && !m_lastwrr;
            for (int i = 0; i < 3; i++) ce[i] = reload ? wt(i) : m_cred[i];
            win  = -1;
            kept = 0;
            if (!m_issue && arb_mode[0] && ch_req != 3'b000) begin
                if (pol == 0) begin
                    f[0] = int'(prio_set[1:0]); f[1] = int'(prio_set[3:2]); f[2] = int'(prio_set[5:4]);
                    if (f[0] > 2 || f[1] > 2 || f[2] > 2 || f[0] == f[1] || f[0] == f[2] || f[1] == f[2])
                        f = '{0, 1, 2};
                end else if (pol == 1) begin
                    for (int k = 0; k < 3; k++) f[k] = (m_ptr + k) % 3;
                end else begin
                    kept = ch_req[m_ptr] && (ce[m_ptr] > 0);
                    if (kept) f = '{m_ptr, m_ptr, m_ptr};
                    else for (int k = 0; k < 3; k++) f[k] = (m_ptr + 1 + k) % 3;
                end
                for (int k = 0; k < 3; k++) if (win < 0 && ch_req[f[k]]) win = f[k];
            end
            eg = (win >= 0) ? oh(win) : 3'b000;
            chk($sformatf("rnd%0d ch_gnt", cyc),  32'(ch_gnt),  32'(eg));
            chk($sformatf("rnd%0d mc_vld", cyc),  32'(mc_vld),  32'(m_issue));
            chk($sformatf("rnd%0d busy", cyc),    32'(busy),    32'(m_issue));
            chk($sformatf("rnd%0d mc_addr", cyc), 32'(mc_addr), 32'(m_addr));
            chk($sformatf("rnd%0d mc_wr", cyc),   32'(mc_wr),   32'(m_wr));
            chk($sformatf("rnd%0d mc_ch", cyc),   32'(mc_ch),   32'(m_ch));
            prev_gnt = eg;
            if (m_issue) begin
                if (mc_ready) begin
                    m_issue = 0;
                    if (m_pol == 1) m_ptr = (m_ch + 1) % 3;
                    else if (m_pol == 2) begin
                        m_ptr         = m_post_ptr;
                        m_cred[m_ch]  = m_post_cred;
                    end
                end
            end else begin
                m_lastwrr = (pol == 2);
                if (reload) for (int i = 0; i < 3; i++) m_cred[i] = wt(i);
                if (win >= 0) begin
                    m_issue = 1; m_ch = win; m_addr = a[win]; m_wr = wrs[win]; m_pol = pol;
                    m_post_ptr  = win;
                    m_post_cred = kept ? ce[win] - 1 : wt(win) - 1;
                end
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
